// File: rtl/svpwm_pkg.sv
// svpwm_pkg: shared leg state encoding, gate index map and dead-time width default
package svpwm_pkg;
  typedef enum logic [1:0] {OFF, DEAD, HIGH, LOW} leg_state_t;
  localparam int GATE_AH = 0;
  localparam int GATE_AL = 3;
  localparam int GATE_BH = 2;
  localparam int GATE_BL = 5;
  localparam int GATE_CH = 4;
  localparam int GATE_CL = 1;
  localparam int DT_W_DEF = 8;
endpackage

// File: rtl/deadtime_gen_if.sv
// deadtime_gen_if: command/protection inputs and gate/status outputs of the dead-time stage
interface deadtime_gen_if import svpwm_pkg::*; #(parameter int DT_W = DT_W_DEF);
  logic [2:0]      switch;
  logic [DT_W-1:0] dead_time;
  logic            enable;
  logic            trip;
  logic            fault_clr;
  logic [5:0]      gate;
  logic            fault;
  logic [2:0]      dead_active;
  modport master (output switch, dead_time, enable, trip, fault_clr, input gate, fault, dead_active);
  modport slave (input switch, dead_time, enable, trip, fault_clr, output gate, fault, dead_active);
endinterface

// File: rtl/deadtime_leg.sv
// deadtime_leg: one half-bridge FSM that forces a full dead interval on every turn-on
module deadtime_leg import svpwm_pkg::*; #(parameter int DT_W = DT_W_DEF) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_i,
  input  logic            off_i,
  input  logic [DT_W-1:0] dt_eff_i,
  output logic            hi_o,
  output logic            lo_o,
  output logic            dead_o
);
  leg_state_t      state_q;
  logic [DT_W-1:0] cnt_q;
  logic            hi_q, lo_q, dead_q;
  logic            go_dead;
  // a reversal while counting is ignored; only the expiry looks at the command
  assign go_dead = state_q == OFF || (state_q == HIGH && !cmd_i) || (state_q == LOW && cmd_i);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= OFF;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      dead_q  <= 1'b0;
    end else if (off_i) begin
      state_q <= OFF;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      dead_q  <= 1'b0;
    end else if (go_dead) begin
      state_q <= DEAD;
      cnt_q   <= dt_eff_i - DT_W'(1);
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      dead_q  <= 1'b1;
    end else if (state_q == DEAD) begin
      if (cnt_q == '0) begin
        state_q <= cmd_i ? HIGH : LOW;
        hi_q    <= cmd_i;
        lo_q    <= !cmd_i;
        dead_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_q - DT_W'(1);
      end
    end
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign dead_o = dead_q;
endmodule

// File: rtl/deadtime_gen.sv
// deadtime_gen: three-leg dead-time insertion with enable gating and latched trip shutdown
module deadtime_gen import svpwm_pkg::*; #(
  parameter int DT_W   = DT_W_DEF,
  parameter int DT_MIN = 2
) (
  input logic           clk,
  input logic           rst_n,
  deadtime_gen_if.slave bus
);
  logic [2:0]      cmd_q;
  logic            fault_q, fault_d;
  logic [DT_W-1:0] dt_eff;
  logic            off;
  logic [2:0]      hi, lo, dead;
  logic [5:0]      gate;
  assign fault_d = bus.trip ? 1'b1 : bus.fault_clr ? 1'b0 : fault_q;
  assign dt_eff  = bus.dead_time < DT_W'(DT_MIN) ? DT_W'(DT_MIN) : bus.dead_time;
  // raw trip joins the shutdown so gates drop on the edge the fault latches
  assign off     = !bus.enable || bus.trip || fault_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cmd_q   <= bus.switch;
      fault_q <= fault_d;
    end
  for (genvar i = 0; i < 3; i++) begin : g_leg
    deadtime_leg #(.DT_W(DT_W)) u_leg (
      .clk(clk), .rst_n(rst_n), .cmd_i(cmd_q[i]), .off_i(off), .dt_eff_i(dt_eff),
      .hi_o(hi[i]), .lo_o(lo[i]), .dead_o(dead[i])
    );
  end
  always_comb begin
    gate          = '0;
    gate[GATE_AH] = hi[0];
    gate[GATE_AL] = lo[0];
    gate[GATE_BH] = hi[1];
    gate[GATE_BL] = lo[1];
    gate[GATE_CH] = hi[2];
    gate[GATE_CL] = lo[2];
  end
  assign bus.gate        = gate;
  assign bus.fault       = fault_q;
  assign bus.dead_active = dead;
endmodule

// File: tb/tb_deadtime_gen.sv
// tb_deadtime_gen: directed and random checks of deadtime_gen against a cycle-level reference model
module tb_deadtime_gen;
  import svpwm_pkg::*;
  localparam int DT_MIN = 2;
  localparam int M_OFF = 0, M_DEAD = 1, M_HI = 2, M_LO = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  deadtime_gen_if #(.DT_W(8)) bus();
  deadtime_gen #(.DT_W(8), .DT_MIN(DT_MIN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  int mst[3];
  int mrem[3];
  bit mcmd[3];
  bit mfault;
  int hi_idx[3] = '{GATE_AH, GATE_BH, GATE_CH};
  int lo_idx[3] = '{GATE_AL, GATE_BL, GATE_CL};
  assert property (@(posedge clk) disable iff (!rst_n)
    !((bus.gate[GATE_AH] & bus.gate[GATE_AL]) | (bus.gate[GATE_BH] & bus.gate[GATE_BL]) |
      (bus.gate[GATE_CH] & bus.gate[GATE_CL])))
    else begin n_fail++; $error("FAIL overlap gate=%b required no leg with both gates", bus.gate); end
  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin mst[i] = M_OFF; mrem[i] = 0; mcmd[i] = 0; end
    mfault = 0;
  endfunction
  // one rising edge: dead interval = max(dead_time, DT_MIN) cycles before any turn-on
  function automatic void model_edge();
    bit off = !bus.enable || bus.trip || mfault;
    int dte = (int'(bus.dead_time) < DT_MIN) ? DT_MIN : int'(bus.dead_time);
    for (int i = 0; i < 3; i++) begin
      if (off) mst[i] = M_OFF;
      else if (mst[i] == M_OFF || (mst[i] == M_HI && !mcmd[i]) || (mst[i] == M_LO && mcmd[i])) begin
        mst[i] = M_DEAD; mrem[i] = dte;
      end
      if (mst[i] == M_DEAD && !off) begin
        mrem[i]--;
        if (mrem[i] < 0) mst[i] = mcmd[i] ? M_HI : M_LO;
      end
      mcmd[i] = bus.switch[i];
    end
    mfault = bus.trip ? 1'b1 : bus.fault_clr ? 1'b0 : mfault;
  endfunction
  function automatic logic [5:0] exp_gate();
    logic [5:0] g = '0;
    for (int i = 0; i < 3; i++) begin
      g[hi_idx[i]] = (mst[i] == M_HI);
      g[lo_idx[i]] = (mst[i] == M_LO);
    end
    return g;
  endfunction
  function automatic logic [2:0] exp_dead();
    logic [2:0] d;
    for (int i = 0; i < 3; i++) d[i] = (mst[i] == M_DEAD);
    return d;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("gate", 32'(bus.gate), 32'(exp_gate()));
    check("fault", 32'(bus.fault), 32'(mfault));
    check("dead_active", 32'(bus.dead_active), 32'(exp_dead()));
  endtask
  // sw applied for the sampling edge, then sw2; count cycles until the leg conducts on want_hi side
  task automatic commute(input logic [2:0] sw, input logic [2:0] sw2, input int leg, input bit want_hi,
                         output int zeros, output int deads, output int ticks);
    zeros = 0; deads = 0; ticks = 0;
    bus.switch = sw;
    tick();
    bus.switch = sw2;
    do begin
      tick();
      ticks++;
      if (!bus.gate[hi_idx[leg]] && !bus.gate[lo_idx[leg]]) zeros++;
      if (bus.dead_active[leg]) deads++;
    end while (bus.gate[want_hi ? hi_idx[leg] : lo_idx[leg]] !== 1'b1 && ticks < 40);
  endtask
  initial begin
    int n, z, d, t;
    bus.switch = '0; bus.dead_time = 8'd5; bus.enable = 0; bus.trip = 0; bus.fault_clr = 0;
    model_reset();
    #12;
    check("rst_gate", 32'(bus.gate), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_dead", 32'(bus.dead_active), 32'd0);
    @(negedge clk) rst_n = 1;
    tick();
    bus.enable = 1;
    n = 0;
    do begin tick(); n++; end while (bus.gate !== 6'b101010 && n < 20);
    check("enable_latency", 32'(n), 32'd6);
    commute(3'b001, 3'b001, 0, 1, z, d, t);
    check("lo2hi_ticks", 32'(t), 32'd6);
    check("lo2hi_dead_cycles", 32'(d), 32'd5);
    check("lo2hi_zero_cycles", 32'(z), 32'd5);
    commute(3'b000, 3'b000, 0, 0, z, d, t);
    check("hi2lo_zero_cycles", 32'(z), 32'd5);
    bus.dead_time = 8'd0;
    commute(3'b001, 3'b001, 0, 1, z, d, t);
    check("clamp_zero_cycles", 32'(z), 32'd2);
    bus.dead_time = 8'd8;
    commute(3'b000, 3'b001, 0, 1, z, d, t);
    check("reversal_zero_cycles", 32'(z), 32'd8);
    check("reversal_returns_hi", 32'(bus.gate[GATE_AH]), 32'd1);
    bus.trip = 1;
    tick();
    check("trip_gate", 32'(bus.gate), 32'd0);
    check("trip_fault", 32'(bus.fault), 32'd1);
    bus.fault_clr = 1;
    tick();
    check("trip_wins", 32'(bus.fault), 32'd1);
    bus.trip = 0;
    tick();
    check("fault_cleared", 32'(bus.fault), 32'd0);
    bus.fault_clr = 0;
    tick();
    check("reentry_dead", 32'(bus.dead_active), 32'd7);
    check("reentry_gate", 32'(bus.gate), 32'd0);
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 7) == 0) bus.switch[i] = ~bus.switch[i];
      if ($urandom_range(0, 31) == 0) bus.dead_time = 8'($urandom_range(0, 12));
      bus.enable = ($urandom_range(0, 99) < 97);
      bus.trip = ($urandom_range(0, 199) == 0);
      bus.fault_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.enable = 1; bus.trip = 0; bus.fault_clr = 1;
    tick();
    bus.fault_clr = 0;
    n = 0;
    do begin tick(); n++; end while (bus.gate === 6'd0 && n < 60);
    check("gates_active_before_reset", 32'(bus.gate != 6'd0), 32'd1);
    #2 rst_n = 0;
    #1;
    check("async_rst_gate", 32'(bus.gate), 32'd0);
    check("async_rst_dead", 32'(bus.dead_active), 32'd0);
    check("async_rst_fault", 32'(bus.fault), 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1;
    for (int c = 0; c < 20; c++) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
